// File: rtl/list_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : list_cmd_pkg
// Description : Shared types for the list command bridge. It holds the FSM
//               state encoding, the default command and response records,
//               and the opcode width.
// Revision    : 1.0 - initial release
// ============================================================================
package list_cmd_pkg;

    localparam int OP_WIDTH         = 3;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_LENGTH_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0]         op;
        logic [DEF_DATA_WIDTH-1:0]   data;
        logic [DEF_LENGTH_WIDTH-1:0] index;
    } list_cmd_t;

    typedef struct packed {
        logic [DEF_LENGTH_WIDTH+DEF_DATA_WIDTH-1:0] data;
        logic                                       error;
        logic                                       timeout;
    } list_rsp_t;

endpackage
`default_nettype wire

// File: rtl/list_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : list_cmd_fifo
// Description : Synchronous FIFO of command records. The head entry is
//               visible combinationally on o_head. A push while the FIFO is
//               full is dropped, and so is a pop while it is empty.
// Ports       : clk, rst          - clock and synchronous active-high reset
//               i_push/i_push_data - write strobe and entry
//               i_pop              - advance the head
//               o_head             - current head entry
//               o_count            - occupancy (0..DEPTH)
//               o_full/o_empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module list_cmd_fifo
    import list_cmd_pkg::*;
#(
    parameter type T     = list_cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  T                       i_push_data,
    input  logic                   i_pop,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    T                   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset: an entry is only read after it is written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/list_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : list_cmd_bridge
// Description : Front-end for the list engine. Commands arrive on a
//               valid/ready stream and are buffered in a small FIFO. They are
//               issued one at a time on op_sel/op_en/data_in/index_in. The
//               bridge waits for op_done and returns data_out/op_error as a
//               valid/ready response. Only one command is outstanding at a
//               time, so responses come back in command order.
// Option      : `define LIST_CMD_BRIDGE_TIMEOUT_EN adds a wait-for-op_done
//               limit of TIMEOUT_CYCLES. When the limit is reached the bridge
//               returns an error response with rsp_timeout set.
// Ports       : cmd_*          - command stream in
//               rsp_*          - response stream out
//               op_sel/op_en/data_in/index_in - issue port to the list
//               data_out/op_done/op_error     - result port from the list
//               op_in_progress - list status; no effect on control
//               busy           - high whenever the FSM is not IDLE
//               cmd_count      - command FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module list_cmd_bridge
    import list_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int LENGTH_WIDTH   = 16,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [OP_WIDTH-1:0]                cmd_op,
    input  logic [DATA_WIDTH-1:0]              cmd_data,
    input  logic [LENGTH_WIDTH-1:0]            cmd_index,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [LENGTH_WIDTH+DATA_WIDTH-1:0] rsp_data,
    output logic                               rsp_error,
    output logic                               rsp_timeout,
    output logic [OP_WIDTH-1:0]                op_sel,
    output logic                               op_en,
    output logic [DATA_WIDTH-1:0]              data_in,
    output logic [LENGTH_WIDTH-1:0]            index_in,
    input  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] data_out,
    input  logic                               op_done,
    input  logic                               op_in_progress,
    input  logic                               op_error,
    output logic                               busy,
    output logic [$clog2(CMD_DEPTH):0]         cmd_count
);

    typedef struct packed {
        logic [OP_WIDTH-1:0]     op;
        logic [DATA_WIDTH-1:0]   data;
        logic [LENGTH_WIDTH-1:0] index;
    } cmd_t;

    state_t r_state;
    state_t w_state_next;
    cmd_t   w_push_data;
    cmd_t   w_head;
    logic   w_push;
    logic   w_pop;
    logic   w_full;
    logic   w_empty;
    logic   w_in_op;
    logic   w_capture;
    logic   w_timeout;
    logic   w_unused_status;

    assign w_unused_status = op_in_progress;

    assign cmd_ready   = !w_full;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_push_data = '{op: cmd_op, data: cmd_data, index: cmd_index};

    list_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (cmd_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

`ifdef LIST_CMD_BRIDGE_TIMEOUT_EN
    localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_rsp_timeout;

    // The counter holds the number of completed cycles in ISSUE/WAIT. It fires
    // on the last allowed cycle, so the bridge spends exactly TIMEOUT_CYCLES
    // cycles waiting before it leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_pop) begin
            r_tmo_cnt <= '0;
        end else if (w_in_op) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end
    end

    assign w_timeout   = w_in_op && !op_done && (r_tmo_cnt == c_tmo_last);
    assign rsp_timeout = r_rsp_timeout;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register and the registered issue/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            op_en     <= 1'b0;
            op_sel    <= '0;
            data_in   <= '0;
            index_in  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
`ifdef LIST_CMD_BRIDGE_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            op_en   <= w_pop;
            // Operands stay latched until the next issue, which keeps them
            // stable for the whole ISSUE/WAIT window.
            if (w_pop) begin
                op_sel   <= w_head.op;
                data_in  <= w_head.data;
                index_in <= w_head.index;
            end
            if (w_capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= data_out;
                rsp_error <= op_error;
`ifdef LIST_CMD_BRIDGE_TIMEOUT_EN
                r_rsp_timeout <= 1'b0;
`endif
            end else if (w_timeout) begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_error <= 1'b1;
`ifdef LIST_CMD_BRIDGE_TIMEOUT_EN
                r_rsp_timeout <= 1'b1;
`endif
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Next-state logic. op_done takes priority over a timeout on the same
    // cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (op_done || w_timeout) begin
                    w_state_next = RESP;
                end else begin
                    w_state_next = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode. op_done is only observed while a command is in flight.
    always_comb begin
        w_pop     = (r_state == IDLE) && !w_empty;
        w_in_op   = (r_state == ISSUE) || (r_state == WAIT);
        w_capture = w_in_op && op_done;
        busy      = (r_state != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_list_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_list_cmd_bridge
// Description : Self-checking bench for list_cmd_bridge. A behavioural list
//               model answers each issue. Its latency is data_in[1:0] cycles
//               after op_en, it returns {index_in, data_in}, and it flags
//               op_error for opcode 7. Expected responses are queued when a
//               command is offered and compared when the response handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_list_cmd_bridge;

    localparam int c_dw = 32;
    localparam int c_lw = 16;
    localparam int c_rw = c_dw + c_lw;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [c_dw-1:0] cmd_data;
    logic [c_lw-1:0] cmd_index;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [c_rw-1:0] rsp_data;
    logic            rsp_error;
    logic            rsp_timeout;
    logic [2:0]      op_sel;
    logic            op_en;
    logic [c_dw-1:0] data_in;
    logic [c_lw-1:0] index_in;
    logic [c_rw-1:0] data_out = '0;
    logic            op_done = 1'b0;
    logic            op_in_progress;
    logic            op_error = 1'b0;
    logic            busy;
    logic [2:0]      cmd_count;

    always #5 clk = ~clk;

    list_cmd_bridge #(
        .DATA_WIDTH     (c_dw),
        .LENGTH_WIDTH   (c_lw),
        .CMD_DEPTH      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .cmd_index      (cmd_index),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .rsp_timeout    (rsp_timeout),
        .op_sel         (op_sel),
        .op_en          (op_en),
        .data_in        (data_in),
        .index_in       (index_in),
        .data_out       (data_out),
        .op_done        (op_done),
        .op_in_progress (op_in_progress),
        .op_error       (op_error),
        .busy           (busy),
        .cmd_count      (cmd_count)
    );

    typedef struct {
        logic [2:0]      op;
        logic [c_dw-1:0] data;
        logic [c_lw-1:0] index;
        logic [c_rw-1:0] exp_data;
        logic            exp_err;
    } vec_t;

    typedef struct {
        logic [c_rw-1:0] data;
        logic            err;
        logic            tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- list model ----------------
    bit         model_en = 1'b1;
    bit         spur_req = 1'b0;
    bit         m_pend   = 1'b0;
    int         m_cnt;
    int         m_delay;
    logic [c_rw-1:0] m_data;
    logic       m_err;

    assign op_in_progress = m_pend;

    always @(negedge clk) begin
        op_done = 1'b0;
        if (rst) begin
            m_pend = 1'b0;
        end else if (spur_req) begin
            op_done  = 1'b1;
            data_out = 48'h0BAD_0BAD0BAD;
            op_error = 1'b0;
            spur_req = 1'b0;
        end else if (op_en && model_en) begin
            m_data  = {index_in, data_in};
            m_err   = (op_sel == 3'd7);
            m_delay = int'(data_in[1:0]);
            m_cnt   = 0;
            if (m_delay == 0) begin
                op_done  = 1'b1;
                data_out = m_data;
                op_error = m_err;
            end else begin
                m_pend = 1'b1;
            end
        end else if (m_pend) begin
            m_cnt++;
            if (m_cnt == m_delay) begin
                op_done  = 1'b1;
                data_out = m_data;
                op_error = m_err;
                m_pend   = 1'b0;
            end
        end
    end

    // ---------------- response scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_rsp: got data %0h, required no response", rsp_data);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_error", 64'(rsp_error), 64'(e.err));
                check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic send(input vec_t v, input bit expect_rsp);
        int   guard = 0;
        exp_t e;
        cmd_op    = v.op;
        cmd_data  = v.data;
        cmd_index = v.index;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        end
        if (expect_rsp) begin
            e.data = v.exp_data;
            e.err  = v.exp_err;
            e.tmo  = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy || cmd_count != 3'd0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];
    vec_t bp[6];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1;
        vec_t v_rst;
        int   n;
        // op 7 marks an erroring command; delay = data[1:0]
        vecs[0] = '{3'd1, 32'h1111_0000, 16'h0001, 48'h0001_11110000, 1'b0};
        vecs[1] = '{3'd7, 32'h2222_0001, 16'h0002, 48'h0002_22220001, 1'b1};
        vecs[2] = '{3'd3, 32'h3333_0002, 16'h0003, 48'h0003_33330002, 1'b0};
        vecs[3] = '{3'd0, 32'hFFFF_FFFF, 16'hFFFF, 48'hFFFF_FFFFFFFF, 1'b0};
        vecs[4] = '{3'd7, 32'h0000_0000, 16'h0000, 48'h0000_00000000, 1'b1};
        vecs[5] = '{3'd5, 32'hA5A5_5A5A, 16'h1234, 48'h1234_A5A55A5A, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bp[i].op       = 3'(i);
            bp[i].data     = 32'hC0DE_0000 + 32'(i);
            bp[i].index    = 16'h0100 + 16'(i);
            bp[i].exp_data = {bp[i].index, bp[i].data};
            bp[i].exp_err  = 1'b0;
        end

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_index = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_count", 64'(cmd_count), 64'd0);
        check("rst_op_en", 64'(op_en), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- single command: exact issue/response timing ----
        v1 = '{3'd2, 32'hDEAD_BEEF, 16'd5, 48'h0005_DEADBEEF, 1'b0};
        cmd_op    = v1.op;
        cmd_data  = v1.data;
        cmd_index = v1.index;
        cmd_valid = 1'b1;
        exp_q.push_back('{v1.exp_data, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t1_count_after_push", 64'(cmd_count), 64'd1);
        check("t1_op_en_k", 64'(op_en), 64'd0);
        @(negedge clk);
        check("t1_op_en_k1", 64'(op_en), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_op_sel", 64'(op_sel), 64'd2);
        @(negedge clk);
        check("t1_op_en_k2", 64'(op_en), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("t1_rsp_valid_early", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain("t1_drain");

        // ---- table vectors (first three cover the error-on-second case) ----
        for (int i = 0; i < 6; i++) begin
            send(vecs[i], 1'b1);
        end
        wait_drain("table_drain");

        // ---- back-pressure ----
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(bp[i], 1'b1);
        end
        cmd_op    = bp[5].op;
        cmd_data  = bp[5].data;
        cmd_index = bp[5].index;
        cmd_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_cmd_count", 64'(cmd_count), 64'd4);
        check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_rsp_data_held", 64'(rsp_data), 64'(bp[0].exp_data));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(bp[5], 1'b1);
        wait_drain("bp_drain");

        // ---- spurious op_done while idle ----
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_rsp_valid", 64'(rsp_valid), 64'd0);
        check("spur_cmd_count", 64'(cmd_count), 64'd0);
        @(posedge clk);
        #1;

        // ---- reset in WAIT with two commands queued ----
        model_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(bp[i], 1'b0);
        end
        @(negedge clk);
        check("prerst_busy", 64'(busy), 64'd1);
        check("prerst_cmd_count", 64'(cmd_count), 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_count", 64'(cmd_count), 64'd0);
        check("rst_mid_op_en", 64'(op_en), 64'd0);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        spur_req = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_late_done_rsp", 64'(rsp_valid), 64'd0);
        check("rst_late_done_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        model_en = 1'b1;

`ifdef LIST_CMD_BRIDGE_TIMEOUT_EN
        // ---- timeout: op_done never arrives ----
        model_en = 1'b0;
        v_rst = '{3'd4, 32'h0000_0001, 16'h0042, 48'h0, 1'b1};
        exp_q.push_back('{48'h0, 1'b1, 1'b1});
        send(v_rst, 1'b0);
        n = 0;
        @(negedge clk);
        while (!op_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("tmo_issue_seen", 64'(op_en), 64'd1);
        n = 0;
        @(negedge clk);
        n++;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 64'(n), 64'd16);
        @(posedge clk);
        #1;
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        check("tmo_late_done", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        model_en = 1'b1;
        wait_drain("tmo_drain");
`else
        v_rst = vecs[0];
        send(v_rst, 1'b1);
        wait_drain("final_drain");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
